// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the multiplexed seven-segment display driver.
package seg_scan_driver_pkg;

    // Number of multiplexed digits on the board.
    localparam int DIGITS = 4;

    // Active-low "everything off" patterns.
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Active-low segment patterns g..a, indexed by hex nibble (entry 0 is the LSB slice).
    localparam logic [15:0][6:0] SEG7_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/seg_scan_driver_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment (g..a) decoder.
module hex_to_seg7
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG7_LUT[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit common-anode seven-segment scan driver with a double-buffered
// value, a blanking gap at the start of each digit slot and optional
// leading-zero suppression.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int DIV_CYCLES   = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [15:0] data_in,
    input  logic        data_valid,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  AN,
    output logic [7:0]  SEG,
    output logic        frame_done
);

    localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0]        cnt_reg;
    logic [1:0]              idx_reg;
    logic [15:0]             shadow_reg;
    logic [DIGITS-1:0]       shadow_dp_reg;
    logic [15:0]             disp_reg;
    logic [DIGITS-1:0]       disp_dp_reg;
    logic [3:0]              an_reg;
    logic [3:0]              an_next;
    logic [7:0]              seg_reg;
    logic [7:0]              seg_next;
    logic                    frame_done_reg;

    logic                    slot_end;
    logic                    frame_end;
    logic [DIGITS-1:0]       lead_zero;
    logic                    suppress;
    logic [3:0]              nibble;
    logic [6:0]              seg_lit;

    assign slot_end  = (cnt_reg == CNT_LAST);
    assign frame_end = slot_end && (idx_reg == 2'd3);

    // Slot timer and digit index: idx moves on the last cycle of each slot.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            cnt_reg <= '0;
            idx_reg <= '0;
        end else if (slot_end) begin
            cnt_reg <= '0;
            idx_reg <= idx_reg + 2'd1;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    // Shadow register: the latest strobe always wins.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            shadow_reg    <= '0;
            shadow_dp_reg <= '0;
        end else if (data_valid) begin
            shadow_reg    <= data_in;
            shadow_dp_reg <= dp_in;
        end
    end

    // Display register only changes at a frame boundary so digits never tear;
    // a strobe landing on the boundary cycle is seen one frame later.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            disp_reg    <= '0;
            disp_dp_reg <= '0;
        end else if (frame_end) begin
            disp_reg    <= shadow_reg;
            disp_dp_reg <= shadow_dp_reg;
        end
    end

    // lead_zero[k] is set when nibbles k..3 of the displayed value are all zero.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lead_zero
        assign lead_zero[gi] = (disp_reg[DIGITS*4-1:gi*4] == '0);
    end

    // Digit 0 always shows, so a zero value still reads "0".
    assign suppress = blank_lz && (idx_reg != 2'd0) && lead_zero[idx_reg];
    assign nibble   = disp_reg[idx_reg*4 +: 4];

    hex_to_seg7 u_dec (
        .nibble (nibble),
        .seg    (seg_lit)
    );

    // Next anode/segment pattern: dark during the anti-ghost gap, else the current digit.
    always_comb begin
        an_next  = AN_OFF;
        seg_next = SEG_OFF;
        if (cnt_reg >= BLANK_LIM) begin
            an_next  = ~(4'b0001 << idx_reg);
            seg_next = {~disp_dp_reg[idx_reg], suppress ? 7'h7F : seg_lit};
        end
    end

    // Registered outputs, one cycle behind the slot timer.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            an_reg         <= AN_OFF;
            seg_reg        <= SEG_OFF;
            frame_done_reg <= 1'b0;
        end else begin
            an_reg         <= an_next;
            seg_reg        <= seg_next;
            frame_done_reg <= frame_end;
        end
    end

    assign AN         = an_reg;
    assign SEG        = seg_reg;
    assign frame_done = frame_done_reg;

endmodule
